// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: baud-select codes, half-bit counts
//               at 50 MHz, and receiver state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] c_baud_2400  = 2'b00;
    localparam logic [1:0] c_baud_4800  = 2'b01;
    localparam logic [1:0] c_baud_9600  = 2'b10;
    localparam logic [1:0] c_baud_19200 = 2'b11;

    localparam logic [14:0] c_half_2400  = 15'd10417;
    localparam logic [14:0] c_half_4800  = 15'd5208;
    localparam logic [14:0] c_half_9600  = 15'd2604;
    localparam logic [14:0] c_half_19200 = 15'd1302;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer with a selectable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8N1/8P1 at four rates, with a single-entry
//               holding register, ready/ack handshake and per-frame errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned      DATA_BITS  = 8,
    parameter int unsigned      CNT_W      = 15,
    parameter logic [CNT_W-1:0] HALF_2400  = CNT_W'(c_half_2400),
    parameter logic [CNT_W-1:0] HALF_4800  = CNT_W'(c_half_4800),
    parameter logic [CNT_W-1:0] HALF_9600  = CNT_W'(c_half_9600),
    parameter logic [CNT_W-1:0] HALF_19200 = CNT_W'(c_half_19200)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [1:0]           baud_rate,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned c_bit_w = $clog2(DATA_BITS);

    logic                 rx_sync;
    logic                 rx_prev_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     half_q;
    logic [c_bit_w-1:0]   bit_cnt_q;
    logic                 par_en_q, par_odd_q, par_bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_ready_q, parity_err_q, frame_err_q, overrun_q;

    logic [CNT_W-1:0]     w_half_sel, w_full;
    logic                 w_edge, w_tick_half, w_tick_full, w_last_bit, w_par_err;
    logic                 w_start, w_shift, w_par_smp, w_done, w_cnt_clr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_sync)
    );

    always_comb begin
        w_half_sel = HALF_2400;
        case (baud_rate)
            c_baud_4800:  w_half_sel = HALF_4800;
            c_baud_9600:  w_half_sel = HALF_9600;
            c_baud_19200: w_half_sel = HALF_19200;
            default:      w_half_sel = HALF_2400;
        endcase
    end

    assign w_edge      = rx_prev_q & ~rx_sync;
    assign w_full      = {half_q[CNT_W-2:0], 1'b0};
    assign w_tick_half = (cnt_q == half_q - CNT_W'(1));
    assign w_tick_full = (cnt_q == w_full - CNT_W'(1));
    assign w_last_bit  = (bit_cnt_q == c_bit_w'(DATA_BITS - 1));
    assign w_par_err   = par_en_q & (par_bit_q ^ (^shift_q) ^ par_odd_q);
    assign cnt_d       = w_cnt_clr ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_edge)      state_d = ST_START;
            ST_START:  if (w_tick_half) state_d = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_tick_full && w_last_bit)
                           state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick_full) state_d = ST_STOP;
            ST_STOP:   if (w_tick_full) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_par_smp = 1'b0;
        w_done    = 1'b0;
        w_cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE:   begin w_start   = w_edge;      w_cnt_clr = 1'b1;        end
            ST_START:  begin                          w_cnt_clr = w_tick_half; end
            ST_DATA:   begin w_shift   = w_tick_full; w_cnt_clr = w_tick_full; end
            ST_PARITY: begin w_par_smp = w_tick_full; w_cnt_clr = w_tick_full; end
            ST_STOP:   begin w_done    = w_tick_full; w_cnt_clr = w_tick_full; end
            default:   begin                          w_cnt_clr = 1'b1;        end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            half_q       <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_ready_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_sync;
            cnt_q     <= cnt_d;
            // Frame configuration is frozen at the start edge
            if (w_start) begin
                half_q    <= w_half_sel;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                bit_cnt_q <= '0;
            end
            if (w_shift) begin
                shift_q   <= {rx_sync, shift_q[DATA_BITS-1:1]};
                bit_cnt_q <= bit_cnt_q + c_bit_w'(1);
            end
            if (w_par_smp) par_bit_q <= rx_sync;

            if (w_done) begin
                if (!rx_ready_q || rx_ack) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= w_par_err;
                    frame_err_q  <= ~rx_sync;
                    rx_ready_q   <= 1'b1;
                    overrun_q    <= 1'b0;
                end else begin
                    overrun_q    <= 1'b1;
                end
            end else if (rx_ack && rx_ready_q) begin
                rx_ready_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_ready   = rx_ready_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire
